// File: rtl/dma_pkg.sv
// Shared types and field layout for the DMA command queue: FSM states,
// descriptor widths and the packing of origin/destination/byte-count.
package dma_pkg;

   localparam int ADDR_W    = 10;
   localparam int CNT_W     = 5;
   localparam int DESC_W    = 2 * ADDR_W + CNT_W;
   localparam int BYTES_LSB = 0;
   localparam int DEST_LSB  = BYTES_LSB + CNT_W;
   localparam int ORIG_LSB  = DEST_LSB + ADDR_W;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      BUSY,
      RETIRE
   } state_t;

   typedef logic [DESC_W-1:0] desc_t;

   function automatic desc_t desc_pack(input logic [ADDR_W-1:0] orig,
                                       input logic [ADDR_W-1:0] dest,
                                       input logic [CNT_W-1:0]  bytes);
      desc_t d;
      d = '0;
      d[ORIG_LSB +: ADDR_W]  = orig;
      d[DEST_LSB +: ADDR_W]  = dest;
      d[BYTES_LSB +: CNT_W]  = bytes;
      return d;
   endfunction

   function automatic logic [ADDR_W-1:0] get_orig(input desc_t d);
      return d[ORIG_LSB +: ADDR_W];
   endfunction

   function automatic logic [ADDR_W-1:0] get_dest(input desc_t d);
      return d[DEST_LSB +: ADDR_W];
   endfunction

   function automatic logic [CNT_W-1:0] get_bytes(input desc_t d);
      return d[BYTES_LSB +: CNT_W];
   endfunction

endpackage

// File: rtl/dma_cmd_queue_if.sv
// Host descriptor push port plus the DMA load/start handshake, bundled so the
// queue and its environment share one connection point.
interface dma_cmd_queue_if;
   import dma_pkg::*;

   logic              desc_valid;
   logic              desc_ready;
   logic [ADDR_W-1:0] desc_orig;
   logic [ADDR_W-1:0] desc_dest;
   logic [CNT_W-1:0]  desc_bytes;

   logic [ADDR_W-1:0] dma_orig;
   logic [ADDR_W-1:0] dma_dest;
   logic [CNT_W-1:0]  dma_bytes;
   logic              dma_load;
   logic              dma_start;
   logic              dma_ack;
   logic              dma_int;

   // master: host + DMA engine side; slave: the command queue itself
   modport master (
      output desc_valid, desc_orig, desc_dest, desc_bytes, dma_ack, dma_int,
      input  desc_ready, dma_orig, dma_dest, dma_bytes, dma_load, dma_start
   );

   modport slave (
      input  desc_valid, desc_orig, desc_dest, desc_bytes, dma_ack, dma_int,
      output desc_ready, dma_orig, dma_dest, dma_bytes, dma_load, dma_start
   );

endinterface

// File: rtl/dma_desc_fifo.sv
// Synchronous descriptor FIFO with a registered head output; a push into the
// slot about to become the head is forwarded so the head is valid immediately.
module dma_desc_fifo
   import dma_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  desc_t                  push_data,
   input  logic                   pop,
   output desc_t                  head,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   desc_t             mem [DEPTH];
   desc_t             head_reg;
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_next;
   logic [LVL_W-1:0]  level_reg;
   logic              do_push;
   logic              do_pop;

   assign full        = (level_reg == LVL_W'(DEPTH));
   assign empty       = (level_reg == '0);
   assign do_push     = push && !full;
   assign do_pop      = pop && !empty;
   assign rd_ptr_next = do_pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Head register reads the slot that will be the head after this edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         head_reg <= '0;
      end else if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
         head_reg <= push_data;
      end else begin
         head_reg <= mem[rd_ptr_next];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         rd_ptr_reg <= rd_ptr_next;
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level_reg <= level_reg + LVL_W'(1);
            2'b01:   level_reg <= level_reg - LVL_W'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

   assign head  = head_reg;
   assign level = level_reg;

endmodule

// File: rtl/dma_cmd_queue.sv
// Command queue front-end for the DMA engine: buffers host descriptors and
// walks each one through load/start/interrupt, with a per-command watchdog.
module dma_cmd_queue
   import dma_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   dma_cmd_queue_if.slave         bus,
   output logic                   busy,
   output logic [7:0]             done_cnt,
   output logic                   err,
   input  logic                   err_clr,
   output logic [$clog2(DEPTH):0] fifo_level
);
   state_t     state_reg;
   state_t     state_next;
   logic [7:0] wdog_reg;
   logic [7:0] done_cnt_reg;
   logic       err_reg;
   logic       dma_load_reg;
   logic       dma_start_reg;
   desc_t      desc_reg;

   desc_t      push_desc;
   desc_t      fifo_head;
   logic       fifo_empty;
   logic       fifo_full;
   logic       fifo_pop;
   logic       capture;
   logic       retire;
   logic       timeout;
   logic       wdog_hit;
   logic       ack_taken;
   logic       wdog_run;

   assign push_desc = desc_pack(bus.desc_orig, bus.desc_dest, bus.desc_bytes);

   dma_desc_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.desc_valid),
      .push_data (push_desc),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .level     (fifo_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign wdog_hit  = (wdog_reg == 8'(TIMEOUT - 1));
   // An ack only counts as a response once load is actually being driven.
   assign ack_taken = bus.dma_ack && dma_load_reg;

   always_comb begin
      state_next = state_reg;
      fifo_pop   = 1'b0;
      capture    = 1'b0;
      retire     = 1'b0;
      timeout    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               capture    = 1'b1;
               state_next = (get_bytes(fifo_head) == '0) ? RETIRE : LOAD;
            end
         end
         LOAD: begin
            if (ack_taken) begin
               state_next = START;
            end else if (wdog_hit) begin
               timeout    = 1'b1;
               fifo_pop   = 1'b1;
               state_next = IDLE;
            end
         end
         START: begin
            state_next = BUSY;
         end
         BUSY: begin
            if (bus.dma_int) begin
               state_next = RETIRE;
            end else if (wdog_hit) begin
               timeout    = 1'b1;
               fifo_pop   = 1'b1;
               state_next = IDLE;
            end
         end
         RETIRE: begin
            fifo_pop   = 1'b1;
            retire     = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Watchdog restarts on every state change and only advances while waiting.
   assign wdog_run = (state_next == state_reg) &&
                     ((state_reg == LOAD) || (state_reg == BUSY));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= IDLE;
         wdog_reg      <= '0;
         done_cnt_reg  <= '0;
         err_reg       <= 1'b0;
         dma_load_reg  <= 1'b0;
         dma_start_reg <= 1'b0;
         desc_reg      <= '0;
      end else begin
         state_reg     <= state_next;
         wdog_reg      <= wdog_run ? wdog_reg + 8'd1 : 8'd0;
         dma_load_reg  <= (state_reg == LOAD) && (state_next == LOAD);
         dma_start_reg <= (state_reg == LOAD) && (state_next == START);
         if (capture) begin
            desc_reg <= fifo_head;
         end
         if (retire) begin
            done_cnt_reg <= done_cnt_reg + 8'd1;
         end
         if (timeout) begin
            err_reg <= 1'b1;
         end else if (err_clr) begin
            err_reg <= 1'b0;
         end
      end
   end

   assign bus.desc_ready = !fifo_full;
   assign bus.dma_orig   = get_orig(desc_reg);
   assign bus.dma_dest   = get_dest(desc_reg);
   assign bus.dma_bytes  = get_bytes(desc_reg);
   assign bus.dma_load   = dma_load_reg;
   assign bus.dma_start  = dma_start_reg;

   assign busy     = (state_reg != IDLE) || !fifo_empty;
   assign done_cnt = done_cnt_reg;
   assign err      = err_reg;

endmodule

// File: tb/tb_dma_cmd_queue.sv
// Randomised self-checking bench for dma_cmd_queue; a descriptor queue plus
// completion/error counters serve as the reference model.
module tb_dma_cmd_queue;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;

   typedef struct packed {
      logic [9:0] orig;
      logic [9:0] dest;
      logic [4:0] bytes;
   } desc_s;

   logic       clk = 1'b0;
   logic       rst;
   logic       err_clr;
   logic       busy;
   logic [7:0] done_cnt;
   logic       err;
   logic [2:0] fifo_level;

   int    checks   = 0;
   int    errors   = 0;
   desc_s model_q[$];
   int    exp_done = 0;
   bit    exp_err  = 1'b0;

   dma_cmd_queue_if bus();

   dma_cmd_queue #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .busy       (busy),
      .done_cnt   (done_cnt),
      .err        (err),
      .err_clr    (err_clr),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic desc_s rand_desc();
      desc_s d;
      d.orig  = 10'($urandom_range(0, 1023));
      d.dest  = 10'($urandom_range(0, 1023));
      d.bytes = 5'($urandom_range(1, 31));
      return d;
   endfunction

   task automatic push_desc(input desc_s d);
      bus.desc_valid = 1'b1;
      bus.desc_orig  = d.orig;
      bus.desc_dest  = d.dest;
      bus.desc_bytes = d.bytes;
      tick();
      bus.desc_valid = 1'b0;
      if (model_q.size() < DEPTH) model_q.push_back(d);
   endtask

   // Drives one command through load/ack/start/int and reports what it saw.
   task automatic serve_head(input int ack_dly, input int int_dly, output bit got_load,
                             output int load_wait, output desc_s seen, output bit start_ok);
      load_wait = 0;
      seen      = '0;
      start_ok  = 1'b0;
      while (bus.dma_load !== 1'b1 && load_wait < 20) begin
         tick();
         load_wait++;
      end
      got_load = (bus.dma_load === 1'b1);
      if (got_load) begin
         seen = {bus.dma_orig, bus.dma_dest, bus.dma_bytes};
         repeat (ack_dly) tick();
         bus.dma_ack = 1'b1;
         tick();
         start_ok = (bus.dma_start === 1'b1) && (bus.dma_load === 1'b0);
         bus.dma_ack = 1'b0;
         tick();
         start_ok = start_ok && (bus.dma_start === 1'b0);
         repeat (int_dly) tick();
         bus.dma_int = 1'b1;
         tick();
         bus.dma_int = 1'b0;
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      checks++; if (bus.desc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.desc_ready); end
      checks++; if (bus.dma_load !== 1'b0) begin errors++; $display("FAIL reset_load got=%b exp=0", bus.dma_load); end
      checks++; if (bus.dma_start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", bus.dma_start); end
      checks++; if (done_cnt !== 8'd0) begin errors++; $display("FAIL reset_done got=%0d exp=0", done_cnt); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
      checks++; if ({bus.dma_orig, bus.dma_dest, bus.dma_bytes} !== 25'd0) begin errors++; $display("FAIL reset_desc got=%h exp=0", {bus.dma_orig, bus.dma_dest, bus.dma_bytes}); end
      rst = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_single();
      desc_s d;
      d = '{orig: 10'h010, dest: 10'h200, bytes: 5'd4};
      push_desc(d);
      checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level got=%0d exp=1", fifo_level); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
      tick();
      checks++; if (bus.dma_load !== 1'b0) begin errors++; $display("FAIL single_load_early got=%b exp=0", bus.dma_load); end
      checks++; if ({bus.dma_orig, bus.dma_dest, bus.dma_bytes} !== d) begin errors++; $display("FAIL single_desc got=%h exp=%h", {bus.dma_orig, bus.dma_dest, bus.dma_bytes}, d); end
      tick();
      checks++; if (bus.dma_load !== 1'b1) begin errors++; $display("FAIL single_load got=%b exp=1", bus.dma_load); end
      bus.dma_ack = 1'b1;
      tick();
      bus.dma_ack = 1'b0;
      checks++; if (bus.dma_start !== 1'b1 || bus.dma_load !== 1'b0) begin errors++; $display("FAIL single_start got=%b/%b exp=1/0", bus.dma_start, bus.dma_load); end
      tick();
      checks++; if (bus.dma_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse got=%b exp=0", bus.dma_start); end
      tick();
      tick();
      bus.dma_int = 1'b1;
      tick();
      bus.dma_int = 1'b0;
      checks++; if (done_cnt !== 8'(exp_done)) begin errors++; $display("FAIL single_done_early got=%0d exp=%0d", done_cnt, exp_done); end
      tick();
      void'(model_q.pop_front());
      exp_done++;
      checks++; if (done_cnt !== 8'(exp_done)) begin errors++; $display("FAIL single_done got=%0d exp=%0d", done_cnt, exp_done); end
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL single_level_end got=%0d exp=0", fifo_level); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", busy); end
      $display("test_single done: done_cnt=%0d", done_cnt);
   endtask

   task automatic test_back_to_back();
      bit    got;
      bit    st_ok;
      int    lw;
      int    n;
      desc_s seen;
      desc_s exp_d;
      for (int round = 0; round < 3; round++) begin
         n = $urandom_range(2, DEPTH);
         for (int i = 0; i < n; i++) push_desc(rand_desc());
         for (int i = 0; i < n; i++) begin
            exp_d = (model_q.size() != 0) ? model_q[0] : '0;
            serve_head($urandom_range(0, 3), $urandom_range(0, 4), got, lw, seen, st_ok);
            checks++; if (!got) begin errors++; $display("FAIL b2b_load_timeout round=%0d cmd=%0d waited=%0d", round, i, lw); end
            checks++; if (seen !== exp_d) begin errors++; $display("FAIL b2b_desc got=%h exp=%h", seen, exp_d); end
            checks++; if (!st_ok) begin errors++; $display("FAIL b2b_start_pulse got=0 exp=1"); end
            if (i > 0) begin
               checks++; if (lw !== 2) begin errors++; $display("FAIL b2b_overhead got=%0d exp=2", lw); end
            end
            void'(model_q.pop_front());
            exp_done++;
            checks++; if (done_cnt !== 8'(exp_done)) begin errors++; $display("FAIL b2b_done got=%0d exp=%0d", done_cnt, exp_done); end
            $display("b2b round=%0d cmd=%0d desc=%h wait=%0d done=%0d", round, i, seen, lw, done_cnt);
         end
      end
   endtask

   task automatic test_full();
      bit    got;
      bit    st_ok;
      int    lw;
      desc_s seen;
      desc_s exp_d;
      desc_s d5;
      for (int i = 0; i < DEPTH; i++) begin
         push_desc(rand_desc());
         checks++; if (bus.desc_ready !== (model_q.size() < DEPTH)) begin errors++; $display("FAIL full_ready push=%0d got=%b exp=%b", i, bus.desc_ready, model_q.size() < DEPTH); end
      end
      d5 = rand_desc();
      bus.desc_valid = 1'b1;
      bus.desc_orig  = d5.orig;
      bus.desc_dest  = d5.dest;
      bus.desc_bytes = d5.bytes;
      tick();
      checks++; if (fifo_level !== 3'(DEPTH)) begin errors++; $display("FAIL full_stall_level got=%0d exp=%0d", fifo_level, DEPTH); end
      tick();
      checks++; if (bus.desc_ready !== 1'b0) begin errors++; $display("FAIL full_stall_ready got=%b exp=0", bus.desc_ready); end
      exp_d = model_q[0];
      serve_head(0, $urandom_range(0, 3), got, lw, seen, st_ok);
      checks++; if (!got || seen !== exp_d) begin errors++; $display("FAIL full_first got=%h exp=%h", seen, exp_d); end
      void'(model_q.pop_front());
      exp_done++;
      checks++; if (bus.desc_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_retire got=%b exp=1", bus.desc_ready); end
      tick();
      bus.desc_valid = 1'b0;
      model_q.push_back(d5);
      checks++; if (fifo_level !== 3'(DEPTH)) begin errors++; $display("FAIL full_fifth_level got=%0d exp=%0d", fifo_level, DEPTH); end
      for (int i = 0; i < DEPTH; i++) begin
         exp_d = (model_q.size() != 0) ? model_q[0] : '0;
         serve_head($urandom_range(0, 3), $urandom_range(0, 4), got, lw, seen, st_ok);
         checks++; if (!got || seen !== exp_d) begin errors++; $display("FAIL full_order cmd=%0d got=%h exp=%h", i, seen, exp_d); end
         void'(model_q.pop_front());
         exp_done++;
         $display("full cmd=%0d desc=%h done=%0d", i, seen, done_cnt);
      end
      checks++; if (done_cnt !== 8'(exp_done)) begin errors++; $display("FAIL full_done got=%0d exp=%0d", done_cnt, exp_done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_end got=%b exp=0", busy); end
   endtask

   task automatic test_zero_len();
      bit    got;
      bit    st_ok;
      int    lw;
      desc_s seen;
      desc_s z;
      desc_s d;
      z = rand_desc();
      z.bytes = 5'd0;
      d = rand_desc();
      d.bytes = 5'd3;
      push_desc(z);
      push_desc(d);
      checks++; if (bus.dma_load !== 1'b0 || bus.dma_bytes !== 5'd0) begin errors++; $display("FAIL zero_capture got load=%b bytes=%0d exp 0/0", bus.dma_load, bus.dma_bytes); end
      tick();
      void'(model_q.pop_front());
      exp_done++;
      checks++; if (done_cnt !== 8'(exp_done)) begin errors++; $display("FAIL zero_done got=%0d exp=%0d", done_cnt, exp_done); end
      checks++; if (bus.dma_load !== 1'b0) begin errors++; $display("FAIL zero_no_load got=%b exp=0", bus.dma_load); end
      checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL zero_level got=%0d exp=1", fifo_level); end
      tick();
      checks++; if (bus.dma_load !== 1'b0) begin errors++; $display("FAIL zero_next_early got=%b exp=0", bus.dma_load); end
      tick();
      checks++; if (bus.dma_load !== 1'b1 || bus.dma_bytes !== 5'd3) begin errors++; $display("FAIL zero_next_load got load=%b bytes=%0d exp 1/3", bus.dma_load, bus.dma_bytes); end
      serve_head(1, 1, got, lw, seen, st_ok);
      checks++; if (!got || seen !== d) begin errors++; $display("FAIL zero_next_desc got=%h exp=%h", seen, d); end
      void'(model_q.pop_front());
      exp_done++;
      checks++; if (done_cnt !== 8'(exp_done)) begin errors++; $display("FAIL zero_done_end got=%0d exp=%0d", done_cnt, exp_done); end
      $display("test_zero_len done: done_cnt=%0d", done_cnt);
   endtask

   task automatic test_timeout();
      push_desc(rand_desc());
      repeat (TIMEOUT) tick();
      checks++; if (err !== 1'b0 || bus.dma_load !== 1'b1) begin errors++; $display("FAIL to_before got err=%b load=%b exp 0/1", err, bus.dma_load); end
      tick();
      void'(model_q.pop_front());
      exp_err = 1'b1;
      checks++; if (err !== exp_err) begin errors++; $display("FAIL to_err got=%b exp=%b", err, exp_err); end
      checks++; if (bus.dma_load !== 1'b0 || fifo_level !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL to_drop got load=%b level=%0d busy=%b exp 0/0/0", bus.dma_load, fifo_level, busy); end
      checks++; if (done_cnt !== 8'(exp_done)) begin errors++; $display("FAIL to_done got=%0d exp=%0d", done_cnt, exp_done); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      exp_err = 1'b0;
      checks++; if (err !== exp_err) begin errors++; $display("FAIL to_clr got=%b exp=%b", err, exp_err); end
      push_desc(rand_desc());
      repeat (TIMEOUT) tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      void'(model_q.pop_front());
      exp_err = 1'b1;
      checks++; if (err !== exp_err) begin errors++; $display("FAIL to_clr_collide got=%b exp=%b", err, exp_err); end
      tick();
      checks++; if (err !== exp_err) begin errors++; $display("FAIL to_sticky got=%b exp=%b", err, exp_err); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      exp_err = 1'b0;
      push_desc(rand_desc());
      tick();
      tick();
      bus.dma_ack = 1'b1;
      tick();
      bus.dma_ack = 1'b0;
      repeat (TIMEOUT) tick();
      checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_busy_before got err=%b busy=%b exp 0/1", err, busy); end
      tick();
      void'(model_q.pop_front());
      exp_err = 1'b1;
      checks++; if (err !== exp_err || fifo_level !== 3'd0) begin errors++; $display("FAIL to_busy got err=%b level=%0d exp 1/0", err, fifo_level); end
      bus.dma_int = 1'b1;
      tick();
      bus.dma_int = 1'b0;
      tick();
      tick();
      checks++; if (done_cnt !== 8'(exp_done) || busy !== 1'b0) begin errors++; $display("FAIL to_late_int got done=%0d busy=%b exp %0d/0", done_cnt, busy, exp_done); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      exp_err = 1'b0;
      checks++; if (err !== exp_err) begin errors++; $display("FAIL to_final_clr got=%b exp=%b", err, exp_err); end
      $display("test_timeout done: done_cnt=%0d", done_cnt);
   endtask

   task automatic test_reset_busy();
      int waited;
      push_desc(rand_desc());
      push_desc(rand_desc());
      waited = 0;
      while (bus.dma_load !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      checks++; if (bus.dma_load !== 1'b1) begin errors++; $display("FAIL rb_load_timeout got=%b exp=1", bus.dma_load); end
      bus.dma_ack = 1'b1;
      tick();
      bus.dma_ack = 1'b0;
      tick();
      checks++; if (fifo_level !== 3'd2 || busy !== 1'b1) begin errors++; $display("FAIL rb_pre got level=%0d busy=%b exp 2/1", fifo_level, busy); end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      model_q.delete();
      exp_done = 0;
      exp_err  = 1'b0;
      checks++; if (fifo_level !== 3'd0 || bus.desc_ready !== 1'b1) begin errors++; $display("FAIL rb_fifo got level=%0d ready=%b exp 0/1", fifo_level, bus.desc_ready); end
      checks++; if (bus.dma_load !== 1'b0 || bus.dma_start !== 1'b0) begin errors++; $display("FAIL rb_ctrl got load=%b start=%b exp 0/0", bus.dma_load, bus.dma_start); end
      checks++; if (done_cnt !== 8'(exp_done) || err !== exp_err) begin errors++; $display("FAIL rb_counters got done=%0d err=%b exp %0d/%b", done_cnt, err, exp_done, exp_err); end
      bus.dma_int = 1'b1;
      tick();
      bus.dma_int = 1'b0;
      tick();
      checks++; if (done_cnt !== 8'(exp_done) || busy !== 1'b0) begin errors++; $display("FAIL rb_late_int got done=%0d busy=%b exp %0d/0", done_cnt, busy, exp_done); end
      $display("test_reset_busy done: done_cnt=%0d", done_cnt);
   endtask

   task automatic test_after_reset();
      bit    got;
      bit    st_ok;
      int    lw;
      desc_s seen;
      desc_s d;
      d = rand_desc();
      push_desc(d);
      serve_head(0, 2, got, lw, seen, st_ok);
      checks++; if (!got || seen !== d) begin errors++; $display("FAIL ar_desc got=%h exp=%h", seen, d); end
      void'(model_q.pop_front());
      exp_done++;
      checks++; if (done_cnt !== 8'(exp_done)) begin errors++; $display("FAIL ar_done got=%0d exp=%0d", done_cnt, exp_done); end
      $display("test_after_reset done: desc=%h done_cnt=%0d", seen, done_cnt);
   endtask

   initial begin
      rst            = 1'b0;
      err_clr        = 1'b0;
      bus.desc_valid = 1'b0;
      bus.desc_orig  = '0;
      bus.desc_dest  = '0;
      bus.desc_bytes = '0;
      bus.dma_ack    = 1'b0;
      bus.dma_int    = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_zero_len();
      test_timeout();
      test_reset_busy();
      test_after_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit reached checks=%0d", checks);
      $fatal(1, "time limit");
   end

endmodule
